// File: rtl/axi_lite_counter_slave.sv
// AXI4-Lite slave owning an 8-bit up/down counter with CTRL/START/COUNT/ID registers.
// The live count is also driven out on count_out for board-level observation.
module axi_lite_counter_slave #(
  parameter int unsigned ADDR_W   = 4,
  parameter int unsigned PRESCALE = 1,
  parameter logic [31:0] ID_VALUE = 32'hDEADBEEF
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic [ADDR_W-1:0] s_axi_awaddr,
  input  logic [2:0]        s_axi_awprot,
  input  logic              s_axi_awvalid,
  output logic              s_axi_awready,
  input  logic [31:0]       s_axi_wdata,
  input  logic [3:0]        s_axi_wstrb,
  input  logic              s_axi_wvalid,
  output logic              s_axi_wready,
  output logic [1:0]        s_axi_bresp,
  output logic              s_axi_bvalid,
  input  logic              s_axi_bready,
  input  logic [ADDR_W-1:0] s_axi_araddr,
  input  logic [2:0]        s_axi_arprot,
  input  logic              s_axi_arvalid,
  output logic              s_axi_arready,
  output logic [31:0]       s_axi_rdata,
  output logic [1:0]        s_axi_rresp,
  output logic              s_axi_rvalid,
  input  logic              s_axi_rready,
  output logic [7:0]        count_out
);

  typedef enum logic [1:0] {
    REG_CTRL  = 2'd0,
    REG_START = 2'd1,
    REG_COUNT = 2'd2,
    REG_ID    = 2'd3
  } reg_sel_e;

  localparam logic [15:0] PS_LAST = 16'(PRESCALE - 1);

  logic       aw_held_q, aw_held_d;
  reg_sel_e   aw_sel_q,  aw_sel_d;
  logic       w_held_q,  w_held_d;
  logic [7:0] wdata_q,   wdata_d;
  logic       wstrb0_q,  wstrb0_d;
  logic       bvalid_q,  bvalid_d;
  logic        rvalid_q, rvalid_d;
  logic [31:0] rdata_q,  rdata_d;
  logic        en_q,     en_d;
  logic        dir_q,    dir_d;
  logic [7:0]  start_q,  start_d;
  logic [7:0]  count_q,  count_d;
  logic [15:0] presc_q,  presc_d;

  logic        aw_hs, w_hs, ar_hs, commit, load, tick;
  logic [31:0] rd_mux;

  // Only lane 0 carries writable state; the rest of the bus is intentionally dropped.
  logic unused_bits;
  assign unused_bits = ^{s_axi_awprot, s_axi_arprot, s_axi_awaddr, s_axi_araddr,
                         s_axi_wdata[31:8], s_axi_wstrb[3:1]};

  assign s_axi_awready = !aw_held_q && !bvalid_q;
  assign s_axi_wready  = !w_held_q && !bvalid_q;
  assign s_axi_arready = !rvalid_q;
  assign s_axi_bvalid  = bvalid_q;
  assign s_axi_bresp   = 2'b00;
  assign s_axi_rvalid  = rvalid_q;
  assign s_axi_rdata   = rdata_q;
  assign s_axi_rresp   = 2'b00;
  assign count_out     = count_q;

  assign aw_hs  = s_axi_awvalid && s_axi_awready;
  assign w_hs   = s_axi_wvalid && s_axi_wready;
  assign ar_hs  = s_axi_arvalid && s_axi_arready;
  assign commit = aw_held_q && w_held_q && !bvalid_q;
  assign load   = commit && (aw_sel_q == REG_START) && wstrb0_q;
  assign tick   = en_q && (presc_q == PS_LAST);

  always_comb begin
    rd_mux = 32'h0;
    case (reg_sel_e'(s_axi_araddr[3:2]))
      REG_CTRL:  rd_mux = {30'h0, dir_q, en_q};
      REG_START: rd_mux = {24'h0, start_q};
      REG_COUNT: rd_mux = {24'h0, count_q};
      REG_ID:    rd_mux = ID_VALUE;
    endcase
  end

  // NOTE: every next-state signal takes its current value first, so no path can infer a latch.
  always_comb begin
    aw_held_d = aw_held_q;
    aw_sel_d  = aw_sel_q;
    w_held_d  = w_held_q;
    wdata_d   = wdata_q;
    wstrb0_d  = wstrb0_q;
    bvalid_d  = bvalid_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    en_d      = en_q;
    dir_d     = dir_q;
    start_d   = start_q;
    count_d   = count_q;
    presc_d   = presc_q;

    if (aw_hs) begin
      aw_held_d = 1'b1;
      aw_sel_d  = reg_sel_e'(s_axi_awaddr[3:2]);
    end
    if (w_hs) begin
      w_held_d = 1'b1;
      wdata_d  = s_axi_wdata[7:0];
      wstrb0_d = s_axi_wstrb[0];
    end
    if (bvalid_q && s_axi_bready) bvalid_d = 1'b0;

    if (commit) begin
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
      bvalid_d  = 1'b1;
      if (wstrb0_q && aw_sel_q == REG_CTRL) begin
        en_d  = wdata_q[0];
        dir_d = wdata_q[1];
      end
      if (wstrb0_q && aw_sel_q == REG_START) start_d = wdata_q;
    end

    // A START load outranks a tick in the same cycle and restarts the prescaler.
    if (load) begin
      count_d = wdata_q;
      presc_d = 16'h0;
    end else if (!en_q) begin
      presc_d = 16'h0;
    end else if (tick) begin
      presc_d = 16'h0;
      count_d = dir_q ? count_q - 8'd1 : count_q + 8'd1;
    end else begin
      presc_d = presc_q + 16'd1;
    end

    if (rvalid_q && s_axi_rready) rvalid_d = 1'b0;
    if (ar_hs) begin
      rvalid_d = 1'b1;
      rdata_d  = rd_mux;
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      aw_held_q <= 1'b0;
      aw_sel_q  <= REG_CTRL;
      w_held_q  <= 1'b0;
      wdata_q   <= 8'h0;
      wstrb0_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= 32'h0;
      en_q      <= 1'b0;
      dir_q     <= 1'b0;
      start_q   <= 8'h0;
      count_q   <= 8'h0;
      presc_q   <= 16'h0;
    end else begin
      aw_held_q <= aw_held_d;
      aw_sel_q  <= aw_sel_d;
      w_held_q  <= w_held_d;
      wdata_q   <= wdata_d;
      wstrb0_q  <= wstrb0_d;
      bvalid_q  <= bvalid_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      en_q      <= en_d;
      dir_q     <= dir_d;
      start_q   <= start_d;
      count_q   <= count_d;
      presc_q   <= presc_d;
    end
  end

endmodule
